// File: rtl/updown_counter_mux_pkg.sv
// ---------------------------------------------------------------------------
// updown_counter_mux_pkg
// Shared constants for the up/down counter with channel demux:
//   DIR_UP / DIR_DOWN : encoding of the dir input
//   DEF_*             : default build parameters of updown_counter_mux
// ---------------------------------------------------------------------------
package updown_counter_mux_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MODULUS = 100;
    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_SEL_W   = 2;
    localparam int DEF_DIV     = 1;

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides enabled cycles by DIV and pulses tick on every DIV-th one.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the phase counter
//   en   : advance the phase counter this cycle
//   clr  : synchronous clear of the phase counter (wins over en)
//   tick : combinational, high on the enabled cycle that completes a period
// ---------------------------------------------------------------------------
module tick_prescaler
    import updown_counter_mux_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A single-bit counter is kept for DIV=1; it simply never leaves 0.
    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = en && !clr && w_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/updown_counter_mux.sv
// ---------------------------------------------------------------------------
// updown_counter_mux
// Modulo-MODULUS up/down counter with prescaler, load/clamp, hold, a wrap
// pulse and a registered demux that routes the count onto one channel.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (count, prescaler, tc, ch_out)
//   en       : count enable
//   hold     : freeze count and prescaler
//   dir      : DIR_UP (0) counts up, DIR_DOWN (1) counts down
//   load     : load strobe, beats hold and stepping
//   load_val : value to load, clamped to MODULUS-1
//   sel      : output channel select
//   count    : registered count, always in 0..MODULUS-1
//   tc       : one-cycle pulse in the cycle after a wrap
//   ch_out   : NUM_CH channels of WIDTH bits; only channel sel carries the
//              count of the previous cycle, the rest are 0
// ---------------------------------------------------------------------------
module updown_counter_mux
    import updown_counter_mux_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DIV     = DEF_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    hold,
    input  logic                    dir,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_val,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        count,
    output logic                    tc,
    output logic [NUM_CH*WIDTH-1:0] ch_out
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0]        r_count;
    logic                    r_tc;
    logic [NUM_CH*WIDTH-1:0] r_ch;
    logic                    w_step;
    logic                    w_pre_en;
    logic [NUM_CH*WIDTH-1:0] w_demux;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        if ({1'b0, v} >= MOD_X) begin
            return MAX_V;
        end
        return v;
    endfunction

    // Prescaler only advances on cycles that are neither held nor loading;
    // load also clears any partial period.
    assign w_pre_en = en && !hold;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_pre_en),
        .clr  (load),
        .tick (w_step)
    );

    always_comb begin
        w_demux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                w_demux[k*WIDTH +: WIDTH] = r_count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ch    <= '0;
        end else begin
            r_tc <= 1'b0;
            r_ch <= w_demux;
            if (load) begin
                r_count <= clamp_load(load_val);
            end else if (!hold && w_step) begin
                if (dir == DIR_UP) begin
                    if (r_count == MAX_V) begin
                        r_count <= '0;
                        r_tc    <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    if (r_count == '0) begin
                        r_count <= MAX_V;
                        r_tc    <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end
        end
    end

    assign count  = r_count;
    assign tc     = r_tc;
    assign ch_out = r_ch;

endmodule

// File: tb/tb_updown_counter_mux.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_mux
// Three builds share one stimulus stream: defaults (index 0), DIV=4
// (index 1) and NUM_CH=3 (index 2). A behavioural model tracks all three.
// ---------------------------------------------------------------------------
module tb_updown_counter_mux;

    localparam int MOD = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       hold = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [1:0] sel = '0;

    logic [7:0]  count_d0, count_d4, count_d3;
    logic        tc_d0, tc_d4, tc_d3;
    logic [31:0] ch_d0, ch_d4;
    logic [23:0] ch_d3;

    int checks = 0;
    int errors = 0;

    // Behavioural model state per build
    int m_count [3];
    int m_pre   [3];
    int m_tc    [3];
    int m_ch    [3][4];
    int m_div   [3] = '{1, 4, 1};
    int m_nch   [3] = '{4, 4, 3};

    always #5 clk = ~clk;

    updown_counter_mux dut0 (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .dir(dir), .load(load),
        .load_val(load_val), .sel(sel), .count(count_d0), .tc(tc_d0), .ch_out(ch_d0)
    );

    updown_counter_mux #(.DIV(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .dir(dir), .load(load),
        .load_val(load_val), .sel(sel), .count(count_d4), .tc(tc_d4), .ch_out(ch_d4)
    );

    updown_counter_mux #(.NUM_CH(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .dir(dir), .load(load),
        .load_val(load_val), .sel(sel), .count(count_d3), .tc(tc_d3), .ch_out(ch_d3)
    );

    function automatic void model_update();
        int nch [4];
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) nch[j] = 0;
            if (int'(sel) < m_nch[i]) nch[int'(sel)] = m_count[i];
            if (rst) begin
                m_count[i] = 0;
                m_pre[i]   = 0;
                m_tc[i]    = 0;
                for (int j = 0; j < 4; j++) m_ch[i][j] = 0;
            end else begin
                for (int j = 0; j < 4; j++) m_ch[i][j] = nch[j];
                m_tc[i] = 0;
                if (load) begin
                    m_count[i] = (int'(load_val) > MOD - 1) ? MOD - 1 : int'(load_val);
                    m_pre[i]   = 0;
                end else if (!hold && en) begin
                    if (m_pre[i] == m_div[i] - 1) begin
                        m_pre[i] = 0;
                        if (dir == 1'b0) begin
                            m_count[i] = (m_count[i] + 1) % MOD;
                            if (m_count[i] == 0) m_tc[i] = 1;
                        end else begin
                            m_tc[i]    = (m_count[i] == 0) ? 1 : 0;
                            m_count[i] = (m_count[i] + MOD - 1) % MOD;
                        end
                    end else begin
                        m_pre[i]++;
                    end
                end
            end
        end
    endfunction

    function automatic logic [31:0] exp_bus(input int i);
        logic [31:0] b;
        b = '0;
        for (int j = 0; j < 4; j++) b[j*8 +: 8] = 8'(m_ch[i][j]);
        return b;
    endfunction

    // One clock edge; model follows the same inputs; outputs sampled 1 after
    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; hold = 0; dir = 0; load = 0; load_val = '0; sel = '0;
    endtask

    task automatic test_reset();
        // Reset must win over load, hold and en
        idle_inputs();
        rst = 1; load = 1; load_val = 8'd55; hold = 1; en = 1; sel = 2'd1;
        advance();
        checks++;
        if (count_d0 !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_d0); end
        checks++;
        if (tc_d0 !== 1'b0) begin errors++; $display("FAIL reset_tc got %0b exp 0", tc_d0); end
        checks++;
        if (ch_d0 !== 32'h0) begin errors++; $display("FAIL reset_ch got %h exp 0", ch_d0); end
        checks++;
        if (count_d4 !== 8'd0 || ch_d3 !== 24'h0) begin
            errors++; $display("FAIL reset_other got %0d/%h exp 0/0", count_d4, ch_d3);
        end
        idle_inputs();
    endtask

    task automatic test_count_up();
        int ntc = 0;
        idle_inputs();
        rst = 1; advance();
        rst = 0; en = 1; dir = 0;
        for (int k = 1; k <= 100; k++) begin
            advance();
            checks++;
            if (count_d0 !== 8'(k % 100)) begin
                errors++; $display("FAIL up_count k=%0d got %0d exp %0d", k, count_d0, k % 100);
            end
            checks++;
            if (tc_d0 !== (k == 100)) begin
                errors++; $display("FAIL up_tc k=%0d got %0b exp %0b", k, tc_d0, (k == 100));
            end
            if (tc_d0 === 1'b1) ntc++;
        end
        checks++;
        if (ntc != 1) begin errors++; $display("FAIL up_tc_total got %0d exp 1", ntc); end
    endtask

    task automatic test_count_down();
        int exp_c [3] = '{99, 98, 97};
        int exp_t [3] = '{1, 0, 0};
        // Continues from count 0 left by test_count_up
        en = 1; dir = 1;
        for (int k = 0; k < 3; k++) begin
            advance();
            checks++;
            if (count_d0 !== 8'(exp_c[k]) || tc_d0 !== 1'(exp_t[k])) begin
                errors++;
                $display("FAIL down step=%0d got %0d/%0b exp %0d/%0d", k, count_d0, tc_d0, exp_c[k], exp_t[k]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_load();
        idle_inputs();
        load = 1; load_val = 8'd150; en = 1;
        advance();
        checks++;
        if (count_d0 !== 8'd99 || tc_d0 !== 1'b0) begin
            errors++; $display("FAIL load_clamp got %0d/%0b exp 99/0", count_d0, tc_d0);
        end
        load_val = 8'd42; hold = 1;
        advance();
        checks++;
        if (count_d0 !== 8'd42 || count_d4 !== 8'd42) begin
            errors++; $display("FAIL load_over_hold got %0d/%0d exp 42", count_d0, count_d4);
        end
        idle_inputs();
    endtask

    task automatic test_prescale();
        idle_inputs();
        rst = 1; advance();
        rst = 0; en = 1;
        for (int c = 1; c <= 10; c++) begin
            advance();
            checks++;
            if (count_d4 !== 8'(c / 4)) begin
                errors++; $display("FAIL div4_count c=%0d got %0d exp %0d", c, count_d4, c / 4);
            end
        end
        // Prescaler is at phase 2 here; reset must discard it
        rst = 1; advance();
        rst = 0;
        for (int c = 1; c <= 4; c++) begin
            advance();
            checks++;
            if (count_d4 !== ((c == 4) ? 8'd1 : 8'd0)) begin
                errors++; $display("FAIL div4_after_rst c=%0d got %0d exp %0d", c, count_d4, (c == 4));
            end
        end
        idle_inputs();
    endtask

    task automatic test_demux();
        idle_inputs();
        load = 1; load_val = 8'd37; advance();
        load = 0; sel = 2'd2; advance();
        checks++;
        if (ch_d0 !== 32'h0025_0000) begin errors++; $display("FAIL demux_sel2 got %h exp 00250000", ch_d0); end
        checks++;
        if (ch_d3 !== 24'h25_0000) begin errors++; $display("FAIL demux3_sel2 got %h exp 250000", ch_d3); end
        sel = 2'd3; advance();
        checks++;
        if (ch_d3 !== 24'h0) begin errors++; $display("FAIL demux3_sel3 got %h exp 000000", ch_d3); end
        checks++;
        if (ch_d0 !== 32'h2500_0000) begin errors++; $display("FAIL demux_sel3 got %h exp 25000000", ch_d0); end
        idle_inputs();
    endtask

    task automatic test_hold();
        idle_inputs();
        load = 1; load_val = 8'd50; advance();
        load = 0; en = 1; advance(); advance();
        // dut0 at 52, dut4 at 50 with phase 2
        hold = 1;
        for (int c = 0; c < 10; c++) begin
            dir = 1'($urandom_range(0, 1));
            advance();
            checks++;
            if (count_d0 !== 8'd52 || count_d4 !== 8'd50 || tc_d0 !== 1'b0 || tc_d4 !== 1'b0) begin
                errors++;
                $display("FAIL hold c=%0d got %0d/%0d tc %0b/%0b exp 52/50 tc 0/0", c, count_d0, count_d4, tc_d0, tc_d4);
            end
        end
        hold = 0; dir = 0;
        advance();
        checks++;
        if (count_d0 !== 8'd53 || count_d4 !== 8'd50) begin
            errors++; $display("FAIL hold_resume1 got %0d/%0d exp 53/50", count_d0, count_d4);
        end
        advance();
        checks++;
        if (count_d4 !== 8'd51) begin errors++; $display("FAIL hold_resume2 got %0d exp 51", count_d4); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] e0, e4, e3;
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            load     = ($urandom_range(0, 9) == 0);
            hold     = ($urandom_range(0, 5) == 0);
            en       = ($urandom_range(0, 3) != 0);
            dir      = (c % 150 >= 75) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            load_val = 8'($urandom_range(0, 255));
            sel      = 2'($urandom_range(0, 3));
            advance();
            e0 = exp_bus(0); e4 = exp_bus(1); e3 = exp_bus(2);
            checks++;
            if (count_d0 !== 8'(m_count[0]) || tc_d0 !== 1'(m_tc[0]) || ch_d0 !== e0) begin
                errors++;
                $display("FAIL rand_d0 c=%0d got %0d/%0b/%h exp %0d/%0d/%h", c, count_d0, tc_d0, ch_d0, m_count[0], m_tc[0], e0);
            end
            checks++;
            if (count_d4 !== 8'(m_count[1]) || tc_d4 !== 1'(m_tc[1]) || ch_d4 !== e4) begin
                errors++;
                $display("FAIL rand_d4 c=%0d got %0d/%0b/%h exp %0d/%0d/%h", c, count_d4, tc_d4, ch_d4, m_count[1], m_tc[1], e4);
            end
            checks++;
            if (count_d3 !== 8'(m_count[2]) || tc_d3 !== 1'(m_tc[2]) || ch_d3 !== e3[23:0]) begin
                errors++;
                $display("FAIL rand_d3 c=%0d got %0d/%0b/%h exp %0d/%0d/%h", c, count_d3, tc_d3, ch_d3, m_count[2], m_tc[2], e3[23:0]);
            end
            checks++;
            if (count_d0 >= 8'(MOD) || count_d4 >= 8'(MOD)) begin
                errors++; $display("FAIL rand_range c=%0d got %0d/%0d exp <%0d", c, count_d0, count_d4, MOD);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_count[i] = 0; m_pre[i] = 0; m_tc[i] = 0;
            for (int j = 0; j < 4; j++) m_ch[i][j] = 0;
        end
        idle_inputs();
        #2;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_prescale();
        test_demux();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
